rf_write_arbiter: RTL and testbench

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

---
 rtl/rf_write_arbiter.sv | 100 ++++++++++
 tb/tb_rf_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: ALU writeback has priority, accelerator results
// queue in a FIFO that is force-drained after STARVE_LIMIT consecutive ALU wins.
module rf_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alu_we,
    input  logic [4:0]             alu_rd,
    input  logic [31:0]            alu_wdata,
    input  logic                   acc_valid,
    input  logic [4:0]             acc_rd,
    input  logic [31:0]            acc_wdata,
    output logic                   acc_ready,
    output logic                   rf_we,
    output logic [4:0]             rf_waddr,
    output logic [31:0]            rf_wdata,
    output logic                   alu_stall,
    output logic [31:0]            pending_mask,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_entry_t;

    wr_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, idx;
    logic [CW-1:0] count_q;
    logic [SW-1:0] starve_q, starve_nxt;
    logic          fifo_empty, alu_take, pop, push;
    logic [31:0]   mask;

    assign fifo_empty = (count_q == '0);
    assign acc_ready  = !reset && (count_q != CW'(DEPTH));
    // rd=0 transfers complete the handshake but are never queued
    assign push       = acc_valid && acc_ready && (acc_rd != 5'd0);
    assign alu_take   = alu_we && (alu_rd != 5'd0) && !alu_stall;
    assign pop        = !alu_take && !fifo_empty;
    assign fifo_count = reset ? '0 : count_q;

    always_comb begin
        starve_nxt = starve_q;
        if (pop || fifo_empty)
            starve_nxt = '0;
        else if (alu_take)
            starve_nxt = starve_q + 1'b1;
    end

    always_comb begin
        mask = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count_q)
                mask[mem[idx].rd] = 1'b1;
        end
        pending_mask = reset ? '0 : mask;
    end

    // Storage needs no reset: occupancy alone decides which slots are live
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{rd: acc_rd, data: acc_wdata};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            alu_stall <= 1'b0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count_q   <= count_q + CW'(push) - CW'(pop);
            starve_q  <= starve_nxt;
            alu_stall <= (starve_nxt == SW'(STARVE_LIMIT));
            rf_we     <= alu_take || pop;
            if (alu_take) begin
                rf_waddr <= alu_rd;
                rf_wdata <= alu_wdata;
            end else if (pop) begin
                rf_waddr <= mem[rd_ptr].rd;
                rf_wdata <= mem[rd_ptr].data;
            end
        end
    end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: a queue-based reference model predicts every
// register-file write; a separate monitor pops and compares each rf_we pulse.
module tb_rf_write_arbiter;
    localparam int DEPTH        = 4;
    localparam int STARVE_LIMIT = 3;

    logic        clk, reset;
    logic        alu_we, acc_valid, acc_ready, rf_we, alu_stall;
    logic [4:0]  alu_rd, acc_rd, rf_waddr;
    logic [31:0] alu_wdata, acc_wdata, rf_wdata, pending_mask;
    logic [$clog2(DEPTH):0] fifo_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_we(alu_we), .alu_rd(alu_rd), .alu_wdata(alu_wdata),
        .acc_valid(acc_valid), .acc_rd(acc_rd), .acc_wdata(acc_wdata),
        .acc_ready(acc_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .alu_stall(alu_stall), .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit [4:0]  rd;
        bit [31:0] data;
    } ent_t;

    ent_t mq[$];     // model of queued accelerator results, oldest first
    ent_t exp_q[$];  // expected register-file writes, in order
    int   starve;
    bit   stall_m;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one cycle of the arbitration rules, evaluated before the edge
    task automatic model_cycle();
        bit [31:0] m;
        bit        eff, popped, was_empty, rdy;
        ent_t      e;
        m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        rdy = !reset && (mq.size() != DEPTH);
        chk("acc_ready", {31'b0, acc_ready}, {31'b0, rdy});
        chk("fifo_count", 32'(fifo_count), reset ? 32'd0 : 32'(mq.size()));
        chk("pending_mask", pending_mask, reset ? 32'd0 : m);
        if (reset) begin
            mq.delete();
            starve  = 0;
            stall_m = 1'b0;
            return;
        end
        chk("alu_stall", {31'b0, alu_stall}, {31'b0, stall_m});
        was_empty = (mq.size() == 0);
        eff       = alu_we && (alu_rd != 0) && !stall_m;
        popped    = 1'b0;
        if (eff) begin
            e.rd = alu_rd; e.data = alu_wdata;
            exp_q.push_back(e);
        end else if (!was_empty) begin
            exp_q.push_back(mq.pop_front());
            popped = 1'b1;
        end
        if (acc_valid && rdy && acc_rd != 0) begin
            e.rd = acc_rd; e.data = acc_wdata;
            mq.push_back(e);
        end
        if (popped || was_empty) starve = 0;
        else if (eff)            starve++;
        stall_m = (starve == STARVE_LIMIT);
    endtask

    task automatic step(input bit we, input bit [4:0] ard, input bit [31:0] ad,
                        input bit av, input bit [4:0] vrd, input bit [31:0] vd, input bit rst);
        alu_we = we; alu_rd = ard; alu_wdata = ad;
        acc_valid = av; acc_rd = vrd; acc_wdata = vd;
        reset = rst;
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write the DUT presents must match the oldest predicted write
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write: got addr=%0d data=0x%0h expected no write at %0t",
                             rf_waddr, rf_wdata, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(rf_waddr), 32'(e.rd));
                    chk("wr_data", rf_wdata, e.data);
                end
            end
        end
    end

    initial begin
        starve = 0; stall_m = 1'b0;
        alu_we = 0; alu_rd = 0; alu_wdata = 0; acc_valid = 0; acc_rd = 0; acc_wdata = 0;
        reset = 1'b1;

        // Reset state
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("rst_rf_we", {31'b0, rf_we}, 0);
        chk("rst_waddr", 32'(rf_waddr), 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_stall", {31'b0, alu_stall}, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_ready", {31'b0, acc_ready}, 0);

        // ALU-only writes, including rd=0
        step(1, 5, 32'hFFFF_FFF0, 0, 0, 0, 0);
        chk("alu_we", {31'b0, rf_we}, 1);
        chk("alu_waddr", 32'(rf_waddr), 5);
        chk("alu_wdata", rf_wdata, 32'hFFFF_FFF0);
        step(1, 0, 32'h1234, 0, 0, 0, 0);
        chk("alu_rd0_we", {31'b0, rf_we}, 0);

        // Fill the FIFO while the ALU holds the port, then drain in order
        for (int i = 1; i <= 4; i++)
            step(1, 9, 32'hA0 + i, 1, 5'(i), 32'h0F + i, 0);
        chk("full_ready", {31'b0, acc_ready}, 0);
        chk("full_count", 32'(fifo_count), 4);
        chk("full_mask", pending_mask, 32'h1E);
        chk("full_stall", {31'b0, alu_stall}, 1);
        step(0, 0, 0, 1, 6, 32'h66, 0);  // pop while full with acc_valid: no push
        chk("pop_full_addr", 32'(rf_waddr), 1);
        chk("pop_full_data", rf_wdata, 32'h10);
        chk("pop_full_count", 32'(fifo_count), 3);
        chk("pop_full_ready", {31'b0, acc_ready}, 1);
        chk("pop_full_mask", pending_mask, 32'h1C);
        for (int k = 2; k <= 4; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("drain_addr", 32'(rf_waddr), 32'(k));
            chk("drain_data", rf_wdata, 32'h10 + 32'(k) - 1);
            chk("drain_mask", pending_mask, 32'h1E & ~((32'h2 << k) - 1));
        end
        step(0, 0, 0, 0, 0, 0, 0);
        chk("drained_we", {31'b0, rf_we}, 0);

        // Starvation: one queued entry against a continuous ALU stream
        step(1, 3, 32'h300, 1, 7, 32'h77, 0);
        for (int j = 0; j < 3; j++) begin
            step(1, 3, 32'h301 + j, 0, 0, 0, 0);
            chk("starve_alu_addr", 32'(rf_waddr), 3);
        end
        chk("starve_stall", {31'b0, alu_stall}, 1);
        step(1, 3, 32'h399, 0, 0, 0, 0);
        chk("starve_pop_addr", 32'(rf_waddr), 7);
        chk("starve_pop_data", rf_wdata, 32'h77);
        chk("starve_stall_clr", {31'b0, alu_stall}, 0);
        step(1, 3, 32'h399, 0, 0, 0, 0);
        chk("starve_resume", rf_wdata, 32'h399);

        // Mid-operation reset with two entries queued
        step(1, 3, 1, 1, 10, 32'hA, 0);
        step(1, 3, 2, 1, 11, 32'hB, 0);
        chk("pre_rst_count", 32'(fifo_count), 2);
        chk("pre_rst_mask", pending_mask, 32'h0C00);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("mid_rst_count", 32'(fifo_count), 0);
        chk("mid_rst_mask", pending_mask, 0);
        chk("mid_rst_we", {31'b0, rf_we}, 0);
        for (int j = 0; j < 3; j++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            chk("post_rst_we", {31'b0, rf_we}, 0);
        end

        // rd=0 accelerator transfer is accepted and dropped
        chk("rd0_ready", {31'b0, acc_ready}, 1);
        step(0, 0, 0, 1, 0, 32'hDEAD, 0);
        chk("rd0_count", 32'(fifo_count), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("rd0_we", {31'b0, rf_we}, 0);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 $urandom, $urandom_range(0, 199) == 0);
        end

        // Drain and confirm every predicted write was observed
        for (int n = 0; n < DEPTH + 3; n++)
            step(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
